// File: rtl/musb_pc_sequencer_pkg.sv
// musb_pc_sequencer_pkg
//   Shared definitions for the MUSB fetch-side PC sequencer:
//   - PC_RESET_DEFAULT : first fetch address after reset
//   - PC_ALIGN_MASK    : clears the byte-offset bits of a fetch address
//   - pcseq_state_e    : sequencer FSM states (RESET, REQ, HOLD)
//   - pc_word_align()  : forces an address onto a word boundary
package musb_pc_sequencer_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    PCSEQ_RESET = 2'd0,
    PCSEQ_REQ   = 2'd1,
    PCSEQ_HOLD  = 2'd2
  } pcseq_state_e;

  function automatic logic [31:0] pc_word_align(input logic [31:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/musb_pc_sequencer.sv
// musb_pc_sequencer
//   Fetch-side program-counter sequencer. Picks the next fetch address from
//   exception redirects, a pending-redirect register, resolved ID-stage
//   branches, or PC+4, and drives the instruction-memory request handshake.
//   Redirects that arrive while no fetch completes are parked in a pending
//   register so none is lost.
//
//   Optional feature macro: MUSB_PC_ALIGN_CHECK_EN
//     defined   : misaligned redirect targets are reported on if_exc_addr_err
//                 and the sequencer waits in HOLD for exc_redirect.
//     undefined : redirect targets are forced to word alignment and
//                 if_exc_addr_err is tied to 0.
//
//   Ports
//     clk, rst            : core clock, synchronous active-high reset
//     if_stall            : IF cannot accept a new instruction
//     id_branch_valid     : take_branch / pc_branch_address are valid
//     take_branch         : branch/jump taken
//     pc_branch_address   : branch/jump target
//     exc_redirect        : exception/ERET redirect pulse
//     exc_address         : exception vector or EPC
//     imem_ready          : instruction memory completes current request
//     imem_req, imem_addr : fetch request and word-aligned address
//     if_pc, if_pc_add4   : PC (and PC+4) of the instruction just completed
//     if_valid            : one-cycle fetch-completed strobe
//     if_exc_addr_err     : misaligned-target strobe (feature macro only)
module musb_pc_sequencer
  import musb_pc_sequencer_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall,
  input  logic        id_branch_valid,
  input  logic        take_branch,
  input  logic [31:0] pc_branch_address,
  input  logic        exc_redirect,
  input  logic [31:0] exc_address,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_add4,
  output logic        if_valid,
  output logic        if_exc_addr_err
);

  pcseq_state_e state_q;
  logic [31:0]  pc_q;
  logic         pend_q;
  logic         pend_exc_q;
  logic [31:0]  pend_addr_q;
  logic         imem_req_q;
  logic [31:0]  if_pc_q;
  logic         if_valid_q;

  logic         branch;
  logic         complete;
  logic         capture_ok;
  logic         redirect;
  logic [31:0]  seq_pc;
  logic [31:0]  target;
  logic [31:0]  next_pc;

`ifdef MUSB_PC_ALIGN_CHECK_EN
  logic         err_wait_q;
  logic         err_show_q;
  logic         addr_err_q;
  logic         target_bad;
`endif

  assign branch   = id_branch_valid & take_branch;
  assign complete = (state_q == PCSEQ_REQ) & imem_ready;
  assign seq_pc   = pc_q + 32'd4;

  // Next-PC priority: exception > pending redirect > branch > sequential.
  always_comb begin
    redirect = 1'b1;
    target   = seq_pc;
    if (exc_redirect) begin
      target = exc_address;
    end else if (pend_q) begin
      target = pend_addr_q;
    end else if (branch) begin
      target = pc_branch_address;
    end else begin
      redirect = 1'b0;
    end
  end

`ifdef MUSB_PC_ALIGN_CHECK_EN
  assign next_pc    = target;
  assign target_bad = redirect & (target[1:0] != 2'b00);
  // While parked on a bad target only exc_redirect matters; it is taken
  // directly by the FSM, so it must not also land in the pending register.
  assign capture_ok = ~complete & ~err_wait_q;
`else
  assign next_pc    = redirect ? pc_word_align(target) : seq_pc;
  assign capture_ok = ~complete;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PCSEQ_RESET;
      pc_q        <= PC_RESET;
      pend_q      <= 1'b0;
      pend_exc_q  <= 1'b0;
      pend_addr_q <= '0;
      imem_req_q  <= 1'b0;
      if_pc_q     <= PC_RESET;
      if_valid_q  <= 1'b0;
`ifdef MUSB_PC_ALIGN_CHECK_EN
      err_wait_q  <= 1'b0;
      err_show_q  <= 1'b0;
      addr_err_q  <= 1'b0;
`endif
    end else begin
      if_valid_q <= 1'b0;
`ifdef MUSB_PC_ALIGN_CHECK_EN
      addr_err_q <= 1'b0;
`endif

      case (state_q)
        PCSEQ_RESET: begin
          state_q    <= PCSEQ_REQ;
          imem_req_q <= 1'b1;
        end

        PCSEQ_REQ: begin
          // pc_q only moves on completion, keeping imem_addr stable
          // for the whole outstanding request.
          if (imem_ready) begin
            if_valid_q <= 1'b1;
            if_pc_q    <= pc_q;
            pc_q       <= next_pc;
`ifdef MUSB_PC_ALIGN_CHECK_EN
            if (target_bad) begin
              state_q    <= PCSEQ_HOLD;
              imem_req_q <= 1'b0;
              err_wait_q <= 1'b1;
              err_show_q <= 1'b1;
            end else
`endif
            if (if_stall) begin
              state_q    <= PCSEQ_HOLD;
              imem_req_q <= 1'b0;
            end
          end
        end

        PCSEQ_HOLD: begin
`ifdef MUSB_PC_ALIGN_CHECK_EN
          // The error strobe is delayed one cycle so it never collides with
          // the if_valid of the delay-slot instruction completing alongside.
          if (err_wait_q) begin
            if (err_show_q) begin
              addr_err_q <= 1'b1;
              if_pc_q    <= pc_q;
              err_show_q <= 1'b0;
            end
            if (exc_redirect) begin
              pc_q <= exc_address;
              if (exc_address[1:0] != 2'b00) begin
                err_show_q <= 1'b1;
              end else begin
                err_wait_q <= 1'b0;
                state_q    <= PCSEQ_REQ;
                imem_req_q <= 1'b1;
              end
            end
          end else
`endif
          if (!if_stall) begin
            state_q    <= PCSEQ_REQ;
            imem_req_q <= 1'b1;
          end
        end

        default: begin
          state_q    <= PCSEQ_RESET;
          imem_req_q <= 1'b0;
        end
      endcase

      // Pending redirect: consumed by any completion, otherwise captures
      // new redirects. A pending exception is never displaced by a branch.
      if (complete) begin
        pend_q     <= 1'b0;
        pend_exc_q <= 1'b0;
      end else if (capture_ok) begin
        if (exc_redirect) begin
          pend_q      <= 1'b1;
          pend_exc_q  <= 1'b1;
          pend_addr_q <= exc_address;
        end else if (branch && !(pend_q && pend_exc_q)) begin
          pend_q      <= 1'b1;
          pend_exc_q  <= 1'b0;
          pend_addr_q <= pc_branch_address;
        end
      end
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign if_pc      = if_pc_q;
  assign if_pc_add4 = if_pc_q + 32'd4;
  assign if_valid   = if_valid_q;

`ifdef MUSB_PC_ALIGN_CHECK_EN
  assign if_exc_addr_err = addr_err_q;
`else
  assign if_exc_addr_err = 1'b0;
`endif

endmodule
